// File: rtl/pq_arb_pkg.sv
// pq_arb_pkg: shared definitions for the priority-queue access arbiter.
//   - pqa_state_e : arbiter FSM state encoding (IDLE/ISSUE/RESP/SETTLE)
//   - OP_DEQ/OP_ENQ : operation-type encoding, also the meaning of the
//     fairness toggle (0 = dequeue wins a tie, 1 = enqueue wins a tie)
//   - pq_clog2 : index width helper, never returns less than 1
package pq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESP   = 2'd2,
    SETTLE = 2'd3
  } pqa_state_e;

  localparam logic OP_DEQ = 1'b0;
  localparam logic OP_ENQ = 1'b1;

  function automatic int pq_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pq_rr_pick.sv
// pq_rr_pick: combinational round-robin selector.
// Returns the first asserted request at index >= ptr_i, wrapping to 0.
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [IW-1:0] highest-priority index this round (must be < N)
//   valid_o          any request asserted
//   idx_o   [IW-1:0] winning index (0 when valid_o is low)
module pq_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// pq_access_arbiter: shares one event priority queue between NUM_CORE cores.
// One queue operation per arbitration round; after each operation the
// arbiter idles SETTLE_CYC cycles so the heap can finish reordering.
//
// Handshake: a core raises enq_req[i]/deq_req[i] and holds it until the
// matching one-cycle ack pulse. The ack marks the cycle the queue strobe is
// issued. Dequeued events come back one cycle after deq_ack as a one-cycle
// deq_valid pulse carrying deq_core/deq_data. There is no back-pressure on
// the response path.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   enq_req/enq_data       per-core enqueue request and event word
//   enq_ack                one-hot accept pulse
//   deq_req/deq_ack        per-core dequeue request and issue pulse
//   deq_valid/core/data    returned event
//   q_enq/q_deq/q_inp_data queue strobes and input word
//   q_out_data/q_full/q_empty  queue head and status
//   busy                   high whenever the FSM is not in IDLE
//   dbg_state              current FSM state
//   stat_*_cnt             op and stall counters (only with PQA_STATS_EN)
//
// Optional macro PQA_STATS_EN adds the statistics counters.
module pq_access_arbiter
  import pq_arb_pkg::*;
#(
  parameter int NUM_CORE   = 4,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int SETTLE_CYC = 2,
  localparam int IW        = pq_clog2(NUM_CORE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORE-1:0]       enq_req,
  input  logic [NUM_CORE*WIDTH-1:0] enq_data,
  output logic [NUM_CORE-1:0]       enq_ack,
  input  logic [NUM_CORE-1:0]       deq_req,
  output logic [NUM_CORE-1:0]       deq_ack,
  output logic                      deq_valid,
  output logic [IW-1:0]             deq_core,
  output logic [WIDTH-1:0]          deq_data,
  output logic                      q_enq,
  output logic                      q_deq,
  output logic [WIDTH-1:0]          q_inp_data,
  input  logic [WIDTH-1:0]          q_out_data,
  input  logic                      q_full,
  input  logic                      q_empty,
  output logic                      busy,
`ifdef PQA_STATS_EN
  output logic [31:0]               stat_enq_cnt,
  output logic [31:0]               stat_deq_cnt,
  output logic [31:0]               stat_stall_cnt,
`endif
  output logic [1:0]                dbg_state
);

  localparam int CW = pq_clog2(SETTLE_CYC + 2);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_CORE   = IW'(NUM_CORE - 1);

  if (NUM_CORE < 2 || DEPTH < 1 || SETTLE_CYC < 0) begin : g_bad_param
    $error("pq_access_arbiter: illegal parameter set");
  end

  pqa_state_e       state_q, state_d;
  logic [IW-1:0]    enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  logic [IW-1:0]    win_q, win_d, deq_core_q, deq_core_d;
  logic             tog_q, tog_d, op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] deq_data_q, deq_data_d;

  logic             enq_pick_v, deq_pick_v, enq_el, deq_el, pick_enq;
  logic [IW-1:0]    enq_pick, deq_pick;
  logic [WIDTH-1:0] enq_word [NUM_CORE];

  for (genvar g = 0; g < NUM_CORE; g++) begin : g_word
    assign enq_word[g] = enq_data[g*WIDTH +: WIDTH];
  end

  pq_rr_pick #(.N(NUM_CORE), .IW(IW)) u_enq_pick (
    .req_i(enq_req), .ptr_i(enq_ptr_q), .valid_o(enq_pick_v), .idx_o(enq_pick)
  );

  pq_rr_pick #(.N(NUM_CORE), .IW(IW)) u_deq_pick (
    .req_i(deq_req), .ptr_i(deq_ptr_q), .valid_o(deq_pick_v), .idx_o(deq_pick)
  );

  // Queue status only matters in IDLE; nothing touches the queue between
  // the decision and the strobe, so it cannot go stale.
  assign enq_el   = enq_pick_v & ~q_full;
  assign deq_el   = deq_pick_v & ~q_empty;
  assign pick_enq = (enq_el && deq_el) ? tog_q : enq_el;

  always_comb begin
    state_d    = state_q;
    enq_ptr_d  = enq_ptr_q;
    deq_ptr_d  = deq_ptr_q;
    win_d      = win_q;
    tog_d      = tog_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    deq_data_d = deq_data_q;
    deq_core_d = deq_core_q;
    q_enq      = 1'b0;
    q_deq      = 1'b0;
    q_inp_data = '0;
    enq_ack    = '0;
    deq_ack    = '0;
    case (state_q)
      IDLE: begin
        if (enq_el || deq_el) begin
          if (enq_el && deq_el) tog_d = ~tog_q;
          if (pick_enq) begin
            op_d      = OP_ENQ;
            win_d     = enq_pick;
            enq_ptr_d = (enq_pick == LAST_CORE) ? '0 : enq_pick + 1'b1;
          end else begin
            op_d      = OP_DEQ;
            win_d     = deq_pick;
            deq_ptr_d = (deq_pick == LAST_CORE) ? '0 : deq_pick + 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (op_q == OP_ENQ) begin
          q_enq          = 1'b1;
          q_inp_data     = enq_word[win_q];
          enq_ack[win_q] = 1'b1;
          if (SETTLE_CYC == 0) state_d = IDLE;
          else                 state_d = SETTLE;
        end else begin
          q_deq          = 1'b1;
          deq_ack[win_q] = 1'b1;
          deq_data_d     = q_out_data;
          deq_core_d     = win_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (SETTLE_CYC == 0) state_d = IDLE;
        else                 state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      enq_ptr_q  <= '0;
      deq_ptr_q  <= '0;
      win_q      <= '0;
      tog_q      <= 1'b0;
      op_q       <= OP_DEQ;
      cnt_q      <= '0;
      deq_data_q <= '0;
      deq_core_q <= '0;
    end else begin
      state_q    <= state_d;
      enq_ptr_q  <= enq_ptr_d;
      deq_ptr_q  <= deq_ptr_d;
      win_q      <= win_d;
      tog_q      <= tog_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      deq_data_q <= deq_data_d;
      deq_core_q <= deq_core_d;
    end
  end

  assign deq_valid = (state_q == RESP);
  assign deq_data  = deq_data_q;
  assign deq_core  = deq_core_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

`ifdef PQA_STATS_EN
  logic [31:0] stat_enq_q, stat_deq_q, stat_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_enq_q   <= '0;
      stat_deq_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (state_q == ISSUE && op_q == OP_ENQ) stat_enq_q <= stat_enq_q + 32'd1;
      if (state_q == ISSUE && op_q == OP_DEQ) stat_deq_q <= stat_deq_q + 32'd1;
      // Pending work that the queue status is blocking.
      if (state_q == IDLE && (enq_pick_v || deq_pick_v) && !(enq_el || deq_el))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_enq_cnt   = stat_enq_q;
  assign stat_deq_cnt   = stat_deq_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_pq_access_arbiter.sv
// tb_pq_access_arbiter: self-checking bench for pq_access_arbiter with a
// behavioural sorted-list queue model standing in for the two-heap queue.
module tb_pq_access_arbiter;

  localparam int NC  = 4;
  localparam int W   = 32;
  localparam int D   = 5;
  localparam int S   = 2;
  localparam int IW  = 2;
  localparam int CAP = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NC-1:0]   enq_req = '0;
  logic [NC-1:0]   deq_req = '0;
  logic [W-1:0]    core_data [NC] = '{default: '0};
  logic [NC*W-1:0] enq_data;
  logic [NC-1:0]   enq_ack, deq_ack;
  logic            deq_valid;
  logic [IW-1:0]   deq_core;
  logic [W-1:0]    deq_data;
  logic            q_enq, q_deq;
  logic [W-1:0]    q_inp_data, q_out_data;
  logic            q_full, q_empty, busy;
  logic [1:0]      dbg_state;
  logic            force_full = 1'b0;

  assign enq_data = {core_data[3], core_data[2], core_data[1], core_data[0]};

  pq_access_arbiter #(
    .NUM_CORE(NC), .WIDTH(W), .DEPTH(D), .SETTLE_CYC(S)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_req(enq_req), .enq_data(enq_data), .enq_ack(enq_ack),
    .deq_req(deq_req), .deq_ack(deq_ack),
    .deq_valid(deq_valid), .deq_core(deq_core), .deq_data(deq_data),
    .q_enq(q_enq), .q_deq(q_deq), .q_inp_data(q_inp_data),
    .q_out_data(q_out_data), .q_full(q_full), .q_empty(q_empty),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- queue model ----------------
  logic [W-1:0] pq [$];
  int           mdl_cnt  = 0;
  logic [W-1:0] mdl_head = '0;

  always @(posedge clk) begin : mdl
    int k;
    if (!rst) begin
      if (q_deq && pq.size() > 0) void'(pq.pop_front());
      if (q_enq) begin
        k = 0;
        while (k < pq.size() && pq[k] <= q_inp_data) k++;
        pq.insert(k, q_inp_data);
      end
    end
    mdl_cnt  <= pq.size();
    mdl_head <= (pq.size() > 0) ? pq[0] : '0;
  end

  assign q_out_data = mdl_head;
  assign q_empty    = (mdl_cnt == 0);
  assign q_full     = force_full || (mdl_cnt >= CAP);

  // ---------------- scoreboard ----------------
  logic [34:0] exp_op_q  [$];  // {op (1=enq), core, q_inp_data}
  logic [33:0] exp_rsp_q [$];  // {core, data}
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc      = 0;
  int          last_cyc = -1;
  logic        last_op  = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [NC-1:0] v);
    oh_idx = '0;
    for (int i = 0; i < NC; i++) if (v[i]) oh_idx = 2'(i);
  endfunction

  task automatic exp_op(input logic op, input logic [1:0] c, input logic [W-1:0] d);
    exp_op_q.push_back({op, c, d});
  endtask

  task automatic exp_rsp(input logic [1:0] c, input logic [W-1:0] d);
    exp_rsp_q.push_back({c, d});
  endtask

  // One clock: sample at negedge, check against scoreboard, retire acked reqs.
  task automatic step();
    logic [34:0] e_op;
    logic [33:0] e_rsp;
    @(negedge clk);
    cyc++;
    if (!q_enq) chk_eq("inp_zero", q_inp_data, 0);
    if (|enq_ack || |deq_ack) begin
      chk_eq("ack_onehot", $onehot({enq_ack, deq_ack}), 1);
      chk_eq("enq_strobe", q_enq, |enq_ack);
      chk_eq("deq_strobe", q_deq, |deq_ack);
      e_op = (exp_op_q.size() > 0) ? exp_op_q.pop_front() : '1;
      chk_eq("op", {|enq_ack, oh_idx(enq_ack | deq_ack), q_inp_data}, e_op);
      if (last_cyc >= 0)
        chk_eq("issue_gap_ok", (cyc - last_cyc) >= (last_op ? 2 + S : 3 + S), 1);
      last_cyc = cyc;
      last_op  = |enq_ack;
    end
    if (deq_valid) begin
      e_rsp = (exp_rsp_q.size() > 0) ? exp_rsp_q.pop_front() : '1;
      chk_eq("rsp", {deq_core, deq_data}, e_rsp);
    end
    enq_req = enq_req & ~enq_ack;
    deq_req = deq_req & ~deq_ack;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (i < budget && (exp_op_q.size() != 0 || exp_rsp_q.size() != 0 ||
                          busy || (enq_req | deq_req) != '0)) begin
      step();
      i++;
    end
    chk_eq("drain", exp_op_q.size() + exp_rsp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] lo, hi;
    int i;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_enq_ack", enq_ack, 0);
    chk_eq("rst_deq_ack", deq_ack, 0);
    chk_eq("rst_deq_valid", deq_valid, 0);
    chk_eq("rst_deq_core", deq_core, 0);
    chk_eq("rst_deq_data", deq_data, 0);
    chk_eq("rst_q_enq", q_enq, 0);
    chk_eq("rst_q_deq", q_deq, 0);
    chk_eq("rst_q_inp", q_inp_data, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Round-robin enqueue from all cores.
    core_data[0] = 40; core_data[1] = 30; core_data[2] = 20; core_data[3] = 10;
    exp_op(1, 0, 40); exp_op(1, 1, 30); exp_op(1, 2, 20); exp_op(1, 3, 10);
    enq_req = 4'hF;
    wait_done(200);

    // Dequeue from core 1 returns the minimum with fixed latency.
    exp_op(0, 1, 0); exp_rsp(1, 10);
    deq_req[1] = 1'b1;
    step(); chk_eq("deq_issue_t1", q_deq, 1);
    step(); chk_eq("deq_resp_t2", deq_valid, 1);
    wait_done(100);

    // Alternation: deq ptr at 2, enq ptr at 0, toggle 0 -> deq first.
    core_data[0] = 80; core_data[3] = 96;
    exp_op(0, 2, 0); exp_op(1, 0, 80); exp_op(0, 1, 0); exp_op(1, 3, 96);
    exp_rsp(2, 20); exp_rsp(1, 30);
    enq_req = 4'b1001;
    deq_req = 4'b0110;
    wait_done(200);

    // Full queue: only the dequeue proceeds until full drops.
    force_full = 1'b1;
    core_data[0] = 112;
    exp_op(0, 1, 0); exp_rsp(1, 40);
    enq_req[0] = 1'b1;
    deq_req[1] = 1'b1;
    repeat (14) step();
    chk_eq("full_enq_held", enq_req[0], 1);
    chk_eq("full_idle", busy, 0);
    force_full = 1'b0;
    exp_op(1, 0, 112);
    wait_done(100);

    // Drain to empty through core 3.
    exp_op(0, 3, 0); exp_rsp(3, 80);  deq_req[3] = 1'b1; wait_done(100);
    exp_op(0, 3, 0); exp_rsp(3, 96);  deq_req[3] = 1'b1; wait_done(100);
    exp_op(0, 3, 0); exp_rsp(3, 112); deq_req[3] = 1'b1; wait_done(100);

    // Empty queue: deq waits, single enq from core 2 unblocks it.
    deq_req[3] = 1'b1;
    repeat (8) step();
    chk_eq("empty_idle", busy, 0);
    chk_eq("empty_deq_held", deq_req[3], 1);
    core_data[2] = 32'h0000_0010;
    exp_op(1, 2, 32'h10); exp_op(0, 3, 0); exp_rsp(3, 32'h10);
    enq_req[2] = 1'b1;
    step();
    chk_eq("single_enq_t1", q_enq, 1);
    chk_eq("single_enq_data", q_inp_data, 32'h10);
    for (int k = 0; k < S; k++) begin
      step();
      chk_eq("settle_busy", busy, 1);
    end
    step();
    chk_eq("settle_idle", busy, 0);
    wait_done(100);

    // Reset during a dequeue issue.
    lo = 32'($urandom_range(1, 500));
    hi = 32'($urandom_range(501, 1000));
    core_data[0] = hi; core_data[1] = lo;
    exp_op(1, 0, hi); exp_op(1, 1, lo);  // enq ptr at 3 -> core 0 first
    enq_req = 4'b0011;
    wait_done(100);
    deq_req[2] = 1'b1;  // latches deq ptr 3 before the reset hits
    i = 0;
    do begin
      @(negedge clk);
      cyc++;
      i++;
    end while (dbg_state != 2'd1 && i < 50);
    chk_eq("reach_issue", dbg_state, 1);
    chk_eq("pre_rst_q_deq", q_deq, 1);
    rst = 1'b1;
    #1;
    chk_eq("rst_mid_q_deq", q_deq, 0);
    chk_eq("rst_mid_deq_ack", deq_ack, 0);
    chk_eq("rst_mid_busy", busy, 0);
    deq_req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_cyc = -1;
    repeat (8) step();
    // Pointer back at 0: core 1 must beat core 3.
    exp_op(0, 1, 0); exp_op(0, 3, 0);
    exp_rsp(1, lo); exp_rsp(3, hi);
    deq_req = 4'b1010;
    wait_done(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
